// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and the future transmitter.
//   uart_rx_state_t : receiver FSM state encoding
//   MIN_BAUD_DIV    : smallest legal clk-cycles-per-bit divisor
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

  localparam int MIN_BAUD_DIV = 4;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: N-stage posedge synchroniser for an asynchronous, idle-high line.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (all stages reset to 1 = line idle)
//   i_d  in  asynchronous input
//   o_q  out synchronised output
// STAGES must be >= 2.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Reset to 1 so that leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rcv_param.sv
// uart_rcv_param: parametrised UART receiver (start + DATA_BITS + [parity] + stop).
//   clk         in   system clock, posedge
//   rst         in   asynchronous active-high reset
//   RX          in   serial line, asynchronous, idles high
//   baud_div    in   clk cycles per bit, latched at the start edge
//   rx_rdy_clr  in   consumer took rx_data; clears rx_rdy and overrun
//   rx_data     out  last received word
//   rx_rdy      out  word valid, sticky until rx_rdy_clr
//   frame_err   out  stop bit of rx_data sampled low
//   par_err     out  parity mismatch for rx_data (0 without parity)
//   overrun     out  a word completed while the previous one was unread
//   busy        out  FSM not idle
// Optional feature: define UART_RCV_PARITY_EN to add a parity bit before stop.
module uart_rcv_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx_rdy_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  output logic                 frame_err,
  output logic                 par_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int               BW       = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  uart_rx_state_t       r_state;
  logic [DIV_W-1:0]     r_div_q;
  logic [DIV_W-1:0]     r_baud;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rdy;
  logic                 r_fe;
  logic                 r_ovr;
`ifdef UART_RCV_PARITY_EN
  localparam logic P_ODD = (PARITY_ODD != 0);
  logic                 r_par_q;
  logic                 r_pe;
`endif

  logic w_rx;
  logic w_tick;
  logic w_half;

  uart_rx_sync #(.STAGES(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (RX),
    .o_q (w_rx)
  );

  // START checks at mid-bit; afterwards every full period lands on a bit centre.
  assign w_half = (r_baud == (r_div_q >> 1));
  assign w_tick = (r_baud == r_div_q - ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_div_q <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_rdy   <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RCV_PARITY_EN
      r_par_q <= 1'b0;
      r_pe    <= 1'b0;
`endif
    end else begin
      // Completion in STOP below overrides a simultaneous clear.
      if (rx_rdy_clr) begin
        r_rdy <= 1'b0;
        r_ovr <= 1'b0;
      end
      case (r_state)
        IDLE: if (!w_rx) begin
          r_state <= START;
          r_baud  <= '0;
          r_bit   <= '0;
          r_div_q <= baud_div;
        end
        START: if (w_half) begin
          r_baud  <= '0;
          r_state <= w_rx ? IDLE : DATA;  // high at mid-start = glitch
        end else r_baud <= r_baud + ONE;
        DATA: if (w_tick) begin
          r_baud  <= '0;
          r_shreg <= {w_rx, r_shreg[DATA_BITS-1:1]};
          r_bit   <= r_bit + 1'b1;
`ifdef UART_RCV_PARITY_EN
          if (r_bit == LAST_BIT) r_state <= PARITY;
`else
          if (r_bit == LAST_BIT) r_state <= STOP;
`endif
        end else r_baud <= r_baud + ONE;
`ifdef UART_RCV_PARITY_EN
        PARITY: if (w_tick) begin
          r_baud  <= '0;
          r_par_q <= w_rx ^ (^r_shreg) ^ P_ODD;
          r_state <= STOP;
        end else r_baud <= r_baud + ONE;
`endif
        STOP: if (w_tick) begin
          r_baud  <= '0;
          r_data  <= r_shreg;
          r_rdy   <= 1'b1;
          r_ovr   <= r_rdy & ~rx_rdy_clr;
          r_fe    <= ~w_rx;
`ifdef UART_RCV_PARITY_EN
          r_pe    <= r_par_q;
`endif
          // A low stop bit may be a line break: hold off until the line idles.
          r_state <= w_rx ? IDLE : BREAK;
        end else r_baud <= r_baud + ONE;
        BREAK: if (w_rx) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_rdy    = r_rdy;
  assign frame_err = r_fe;
  assign overrun   = r_ovr;
  assign busy      = (r_state != IDLE);
`ifdef UART_RCV_PARITY_EN
  assign par_err   = r_pe;
`else
  assign par_err   = 1'b0;
`endif

  // Divisor is only meaningful once latched; check it at the start edge.
  a_min_div: assert property (@(posedge clk) disable iff (rst)
    (r_state == IDLE && !w_rx) |-> (baud_div >= DIV_W'(MIN_BAUD_DIV)));

endmodule

// File: tb/tb_uart_rcv_param.sv
module tb_uart_rcv_param;

`ifdef UART_RCV_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1, RX5 = 1'b1;
  logic [15:0] baud_div = 16'd16, baud_div5 = 16'd16;
  logic        clr = 1'b0, clr5 = 1'b0;
  logic [7:0]  rx_data;
  logic [4:0]  rx_data5;
  logic        rdy, fe, pe, ovr, busy;
  logic        rdy5, fe5, pe5, ovr5, busy5;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, rise_cyc = 0;
  logic prev_rdy = 1'b0;

  // Reference model of what the consumer should see on the 8-bit receiver.
  logic [7:0] m_data = '0;
  logic       m_rdy = 0, m_ovr = 0, m_fe = 0, m_pe = 0;

  uart_rcv_param #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .RX(RX), .baud_div(baud_div), .rx_rdy_clr(clr),
    .rx_data(rx_data), .rx_rdy(rdy), .frame_err(fe), .par_err(pe),
    .overrun(ovr), .busy(busy));

  uart_rcv_param #(.DATA_BITS(5), .DIV_W(16)) dut5 (
    .clk(clk), .rst(rst), .RX(RX5), .baud_div(baud_div5), .rx_rdy_clr(clr5),
    .rx_data(rx_data5), .rx_rdy(rdy5), .frame_err(fe5), .par_err(pe5),
    .overrun(ovr5), .busy(busy5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rdy && !prev_rdy) rise_cyc = cyc;
    prev_rdy = rdy;
  end

  task automatic drive_bit(input int sel, input logic b, input int div);
    if (sel == 0) RX = b; else RX5 = b;
    repeat (div) @(negedge clk);
  endtask

  // Whole frame on the line; updates the model when targeting the 8-bit DUT.
  task automatic send_frame(input int sel, input logic [8:0] d, input int nb, input int div,
                            input logic stop_b, input logic bad_par, input logic clr_at_done);
    if (sel == 0) begin start_cyc = cyc; baud_div = 16'(div); end
    else baud_div5 = 16'(div);
    drive_bit(sel, 1'b0, div);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i], div);
`ifdef UART_RCV_PARITY_EN
    drive_bit(sel, (^d) ^ bad_par, div);  // even parity, optionally corrupted
`endif
    drive_bit(sel, stop_b, div);
    if (sel == 0) begin
      m_ovr  = m_rdy && !clr_at_done;
      m_rdy  = 1'b1;
      m_data = d[7:0];
      m_fe   = ~stop_b;
      m_pe   = (PAR == 1) ? bad_par : 1'b0;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rx_data, rdy, fe, pe, ovr, busy, rx_data5, rdy5, fe5, pe5, ovr5, busy5} !== 23'd0) begin
      n_err++; $display("FAIL reset_in got=%h exp=0", {rx_data, rdy, fe, pe, ovr, busy, rx_data5, rdy5, fe5, pe5, ovr5, busy5});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_data, rdy, fe, pe, ovr, busy, rx_data5, rdy5, fe5, pe5, ovr5, busy5} !== 23'd0) begin
      n_err++; $display("FAIL reset_out got=%h exp=0", {rx_data, rdy, fe, pe, ovr, busy, rx_data5, rdy5, fe5, pe5, ovr5, busy5});
    end
  endtask

  task automatic test_basic();
    int lat, lo;
    send_frame(0, 9'h0A5, 8, 2604, 1'b1, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 100);
    n_cmp++;
    if ({rx_data, rdy, fe, pe, ovr} !== {m_data, m_rdy, m_fe, m_pe, m_ovr}) begin
      n_err++; $display("FAIL basic_word got=%h exp=%h", {rx_data, rdy, fe, pe, ovr}, {m_data, m_rdy, m_fe, m_pe, m_ovr});
    end
    // Stop-bit centre: (1 + bits + 0.5) bit times after the start edge, plus sync delay.
    lat = rise_cyc - start_cyc;
    lo  = (2 * (8 + PAR) + 3) * 2604 / 2;
    n_cmp++;
    if (lat < lo || lat > lo + 8) begin
      n_err++; $display("FAIL basic_latency got=%0d exp=%0d..%0d", lat, lo, lo + 8);
    end
  endtask

  task automatic test_false_start();
    bit dropped;
    pulse_clr();
    baud_div = 16'd2604;
    drive_bit(0, 1'b0, 1000);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL fs_busy got=%b exp=1", busy); end
    RX = 1'b1;
    dropped = 0;
    for (int i = 0; i < 2604 && !dropped; i++) begin
      @(negedge clk);
      if (busy === 1'b0) dropped = 1;
    end
    n_cmp++;
    if (!dropped) begin n_err++; $display("FAIL fs_idle got=busy exp=idle_within_bit"); end
    drive_bit(0, 1'b1, 3000);
    n_cmp++;
    if ({rdy, ovr, busy} !== 3'b000) begin
      n_err++; $display("FAIL fs_flags got=%b exp=000", {rdy, ovr, busy});
    end
  endtask

  task automatic test_overrun();
    int div = $urandom_range(20, 4);
    send_frame(0, 9'h03C, 8, div, 1'b1, 1'b0, 1'b0);
    drive_bit(0, 1'b1, div);
    send_frame(0, 9'h081, 8, div, 1'b1, 1'b0, 1'b0);
    drive_bit(0, 1'b1, div);
    n_cmp++;
    if ({rx_data, rdy, fe, pe, ovr} !== {m_data, m_rdy, m_fe, m_pe, m_ovr} || ovr !== 1'b1) begin
      n_err++; $display("FAIL ovr_word got=%h exp=%h", {rx_data, rdy, fe, pe, ovr}, {m_data, m_rdy, m_fe, m_pe, m_ovr});
    end
    pulse_clr();
    @(negedge clk);
    n_cmp++;
    if ({rdy, ovr} !== 2'b00) begin n_err++; $display("FAIL ovr_clr got=%b exp=00", {rdy, ovr}); end
  endtask

  task automatic test_break();
    int div = $urandom_range(20, 4);
    bit dropped;
    send_frame(0, 9'($urandom_range(255, 0)), 8, div, 1'b0, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 5 * div);
    n_cmp++;
    if ({rx_data, rdy, fe, pe, ovr, busy} !== {m_data, m_rdy, m_fe, m_pe, m_ovr, 1'b1}) begin
      n_err++; $display("FAIL brk_word got=%h exp=%h", {rx_data, rdy, fe, pe, ovr, busy}, {m_data, m_rdy, m_fe, m_pe, m_ovr, 1'b1});
    end
    RX = 1'b1;
    dropped = 0;
    for (int i = 0; i < 10 && !dropped; i++) begin
      @(negedge clk);
      if (busy === 1'b0) dropped = 1;
    end
    n_cmp++;
    if (!dropped) begin n_err++; $display("FAIL brk_release got=busy exp=idle"); end
    drive_bit(0, 1'b1, div);
    pulse_clr();
    send_frame(0, 9'h055, 8, div, 1'b1, 1'b0, 1'b0);
    drive_bit(0, 1'b1, div);
    n_cmp++;
    if ({rx_data, rdy, fe, pe, ovr} !== {m_data, m_rdy, m_fe, m_pe, m_ovr}) begin
      n_err++; $display("FAIL brk_next got=%h exp=%h", {rx_data, rdy, fe, pe, ovr}, {m_data, m_rdy, m_fe, m_pe, m_ovr});
    end
  endtask

  task automatic test_parity();
`ifdef UART_RCV_PARITY_EN
    for (int k = 0; k < 2; k++) begin
      pulse_clr();
      send_frame(0, 9'h007, 8, 12, 1'b1, k[0], 1'b0);
      drive_bit(0, 1'b1, 12);
      n_cmp++;
      if ({rx_data, rdy, fe, pe, ovr} !== {m_data, m_rdy, m_fe, m_pe, m_ovr}) begin
        n_err++; $display("FAIL parity_%0d got=%h exp=%h", k, {rx_data, rdy, fe, pe, ovr}, {m_data, m_rdy, m_fe, m_pe, m_ovr});
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      int div = $urandom_range(20, 4);
      if ($urandom_range(1, 0) == 1) pulse_clr();
      send_frame(0, 9'($urandom_range(255, 0)), 8, div, 1'b1, 1'($urandom_range(PAR, 0)), 1'b0);
      drive_bit(0, 1'b1, div * $urandom_range(3, 1));
      n_cmp++;
      if ({rx_data, rdy, fe, pe, ovr} !== {m_data, m_rdy, m_fe, m_pe, m_ovr}) begin
        n_err++; $display("FAIL rand_%0d got=%h exp=%h", n, {rx_data, rdy, fe, pe, ovr}, {m_data, m_rdy, m_fe, m_pe, m_ovr});
      end
    end
  endtask

  // Clear lands exactly on the completion cycle: new word wins, no overrun.
  task automatic test_back_to_back();
    int lat, tgt;
    pulse_clr();
    send_frame(0, 9'h0C3, 8, 8, 1'b1, 1'b0, 1'b0);
    drive_bit(0, 1'b1, 8);
    lat = rise_cyc - start_cyc;
    tgt = cyc + lat - 1;
    fork
      send_frame(0, 9'h05A, 8, 8, 1'b1, 1'b0, 1'b1);
      begin
        while (cyc < tgt) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
    join
    drive_bit(0, 1'b1, 8);
    n_cmp++;
    if ({rx_data, rdy, fe, pe, ovr} !== {m_data, m_rdy, m_fe, m_pe, m_ovr}) begin
      n_err++; $display("FAIL b2b_clr got=%h exp=%h", {rx_data, rdy, fe, pe, ovr}, {m_data, m_rdy, m_fe, m_pe, m_ovr});
    end
  endtask

  task automatic test_reset_mid();
    send_frame(1, 9'h00A, 5, 16, 1'b1, 1'b0, 1'b0);
    drive_bit(1, 1'b1, 16);
    n_cmp++;
    if ({rx_data5, rdy5} !== {5'h0A, 1'b1}) begin
      n_err++; $display("FAIL rst5_pre got=%h exp=%h", {rx_data5, rdy5}, {5'h0A, 1'b1});
    end
    drive_bit(1, 1'b0, 16);  // start
    drive_bit(1, 1'b1, 16);  // d0
    drive_bit(1, 1'b0, 8);   // halfway through d1
    rst = 1'b1;
    RX5 = 1'b1;
    repeat (2) @(negedge clk);
    m_data = '0; m_rdy = 0; m_ovr = 0; m_fe = 0; m_pe = 0;
    n_cmp++;
    if ({rx_data5, rdy5, fe5, pe5, ovr5, busy5, rx_data, rdy, fe, pe, ovr, busy} !== 23'd0) begin
      n_err++; $display("FAIL rst5_mid got=%h exp=0", {rx_data5, rdy5, fe5, pe5, ovr5, busy5, rx_data, rdy, fe, pe, ovr, busy});
    end
    rst = 1'b0;
    drive_bit(1, 1'b1, 160);
    send_frame(1, 9'h01F, 5, 16, 1'b1, 1'b0, 1'b0);
    drive_bit(1, 1'b1, 16);
    n_cmp++;
    if ({rx_data5, rdy5, fe5, pe5, ovr5} !== {5'h1F, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL rst5_next got=%h exp=%h", {rx_data5, rdy5, fe5, pe5, ovr5}, {5'h1F, 4'b1000});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_overrun();
    test_break();
    test_parity();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
